inst_mem_pipe: RTL and testbench



---
 rtl/inst_mem_pipe.sv | 178 +++++++++++++++++
 tb/tb_inst_mem_pipe.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_pipe.sv
// Synchronous instruction memory: valid/ready fetch in, valid/ready response out, program-load port.
// One-cycle latency when empty; holds two outstanding fetches, req_ready drops at two until a pop.

module sync_fifo #(
   parameter int W = 8,
   parameter int D = 2,
   parameter int CW = $clog2(D) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          wr_vld,
   input  logic [W-1:0]  wr_dat,
   input  logic          rd_rdy,
   output logic          rd_vld,
   output logic [W-1:0]  rd_dat,
   output logic [CW-1:0] cnt
);
   localparam int AW = (D > 1) ? $clog2(D) : 1;

   logic [W-1:0]  buf_q [D];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic          pop;

   function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
      return (p == AW'(D - 1)) ? '0 : p + 1'b1;
   endfunction

   assign rd_vld = (cnt != '0);
   assign rd_dat = buf_q[rp];
   assign pop    = rd_vld && rd_rdy;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (wr_vld) begin
            buf_q[wp] <= wr_dat;
            wp        <= nxt(wp);
         end
         if (pop)
            rp <= nxt(rp);
         cnt <= cnt + CW'(wr_vld) - CW'(pop);
      end
   end
endmodule

module inst_mem_pipe #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 1024,
   parameter     INIT_FILE = ""
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              req_ready,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic [ADDR_W-1:0] resp_addr,
   output logic [1:0]        resp_err,
   input  logic              flush,
   input  logic              ld_en,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data
);
   localparam int LW = $clog2(DEPTH);
   localparam int EW = DATA_W + ADDR_W + 2;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] mem_q;

   logic [LW-1:0]     req_idx;
   logic [LW-1:0]     ld_idx;
   logic [1:0]        req_err;
   logic              ld_oor;
   logic              accept;
   logic              rd_en;

   logic              rd_vld;
   logic [ADDR_W-1:0] rd_addr;
   logic [1:0]        rd_err;
   logic [DATA_W-1:0] rd_data;

   logic              fifo_wr_vld;
   logic              fifo_rd_rdy;
   logic              fifo_rd_vld;
   logic [EW-1:0]     fifo_rd_dat;
   logic [1:0]        fifo_cnt;
   logic [1:0]        occ;
   logic              pop;
   logic              pop_rd;

   logic [DATA_W-1:0] hd_data;
   logic [ADDR_W-1:0] hd_addr;
   logic [1:0]        hd_err;

   wire unused_ld_lsb = &{1'b0, ld_addr[1:0]};

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
   end

   assign req_idx    = req_addr[LW+1:2];
   assign ld_idx     = ld_addr[LW+1:2];
   assign req_err[0] = (req_addr[1:0] != 2'b00);
   assign req_err[1] = ((req_addr >> (LW + 2)) != '0);
   assign ld_oor     = ((ld_addr >> (LW + 2)) != '0);

   // Occupancy comes only from registered state, so resp_ready never reaches req_ready.
   assign occ       = fifo_cnt + {1'b0, rd_vld};
   assign req_ready = !rst && !flush && (occ < 2'd2);
   assign accept    = req_valid && req_ready;
   assign rd_en     = accept && (req_err == 2'b00);

   always_ff @(posedge clk) begin
      if (!rst && ld_en && !ld_oor)
         mem[ld_idx] <= ld_data;
   end

   // Separate read register keeps the read-first behaviour of a block RAM.
   always_ff @(posedge clk) begin
      if (rd_en)
         mem_q <= mem[req_idx];
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_vld  <= 1'b0;
         rd_addr <= '0;
         rd_err  <= 2'b00;
      end else begin
         rd_vld <= accept;
         if (accept) begin
            rd_addr <= req_addr;
            rd_err  <= req_err;
         end
      end
   end

   assign rd_data = (rd_err != 2'b00) ? '0 : mem_q;

   // Read stage is always the youngest entry; older ones wait in the FIFO.
   assign pop         = resp_valid && resp_ready && !flush;
   assign pop_rd      = pop && !fifo_rd_vld;
   assign fifo_wr_vld = rd_vld && !pop_rd && !flush;
   assign fifo_rd_rdy = resp_ready && !flush;

   sync_fifo #(.W(EW), .D(2), .CW(2)) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .clr    (flush),
      .wr_vld (fifo_wr_vld),
      .wr_dat ({rd_err, rd_addr, rd_data}),
      .rd_rdy (fifo_rd_rdy),
      .rd_vld (fifo_rd_vld),
      .rd_dat (fifo_rd_dat),
      .cnt    (fifo_cnt)
   );

   always_comb begin
      hd_err  = rd_err;
      hd_addr = rd_addr;
      hd_data = rd_data;
      if (fifo_rd_vld)
         {hd_err, hd_addr, hd_data} = fifo_rd_dat;
   end

   assign resp_valid = fifo_rd_vld || rd_vld;
   assign resp_data  = resp_valid ? hd_data : '0;
   assign resp_addr  = resp_valid ? hd_addr : '0;
   assign resp_err   = resp_valid ? hd_err  : 2'b00;
endmodule

// File: tb/tb_inst_mem_pipe.sv
// Bench for inst_mem_pipe: directed plan steps followed by random traffic against a queue model.

module tb_inst_mem_pipe;
   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        req_ready;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;
   logic [31:0] resp_addr;
   logic [1:0]  resp_err;
   logic        flush;
   logic        ld_en;
   logic [31:0] ld_addr;
   logic [31:0] ld_data;

   typedef struct {
      logic [31:0] d;
      logic [31:0] a;
      logic [1:0]  e;
   } rsp_t;

   rsp_t        q[$];
   logic [31:0] mdl [1024];
   int          checks = 0;
   int          errors = 0;

   inst_mem_pipe dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_addr   (req_addr),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_addr  (resp_addr),
      .resp_err   (resp_err),
      .flush      (flush),
      .ld_en      (ld_en),
      .ld_addr    (ld_addr),
      .ld_data    (ld_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, check req_ready, advance the model, check the response head.
   task automatic cycle(input logic rv, input logic [31:0] ra, input logic rr, input logic fl,
                        input logic rs, input logic le, input logic [31:0] la, input logic [31:0] ldv);
      logic acc;
      logic exp_rdy;
      rsp_t r;
      req_valid = rv; req_addr = ra; resp_ready = rr; flush = fl;
      rst = rs; ld_en = le; ld_addr = la; ld_data = ldv;
      #1;
      exp_rdy = !rs && !fl && (q.size() < 2);
      chk("req_ready", {31'b0, req_ready}, {31'b0, exp_rdy});
      acc = rv && exp_rdy;
      r.a = ra;
      r.e = {(ra / 4) >= 1024, (ra % 4) != 0};
      r.d = (r.e != 2'b00) ? 32'h0 : mdl[ra[11:2]];
      if (rs || fl) begin
         q.delete();
      end else begin
         if (rr && q.size() > 0) void'(q.pop_front());
         if (acc) q.push_back(r);
      end
      if (le && !rs && (la / 4) < 1024) mdl[la[11:2]] = ldv;
      @(posedge clk);
      #1;
      chk("resp_valid", {31'b0, resp_valid}, {31'b0, q.size() > 0});
      if (q.size() > 0) begin
         chk("resp_data", resp_data, q[0].d);
         chk("resp_addr", resp_addr, q[0].a);
         chk("resp_err", 32'(resp_err), 32'(q[0].e));
      end
   endtask

   task automatic fetch(input logic [31:0] a, input logic rr);
      cycle(1'b1, a, rr, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic idle(input logic rr);
      cycle(1'b0, 32'h0, rr, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   initial begin
      logic [31:0] prog [4];
      logic [31:0] a;
      logic [31:0] la;
      int          p;
      prog[0] = 32'h34011100; prog[1] = 32'h34020020;
      prog[2] = 32'h00220019; prog[3] = 32'h3403ffff;
      for (int i = 0; i < 1024; i++) mdl[i] = 32'h0;

      // reset state
      cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
      cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
      chk("rst_data", resp_data, 32'h0);
      chk("rst_addr", resp_addr, 32'h0);
      chk("rst_err", 32'(resp_err), 32'h0);

      for (int i = 0; i < 4; i++)
         cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'(i * 4), prog[i]);

      // back-to-back fetches at full rate
      fetch(32'h0, 1'b1);
      chk("t1_first", resp_data, 32'h34011100);
      fetch(32'h4, 1'b1);
      fetch(32'h8, 1'b1);
      fetch(32'hc, 1'b1);
      chk("t1_last", resp_data, 32'h3403ffff);
      idle(1'b1);

      // back-pressure: two outstanding, third refused, head held
      fetch(32'h0, 1'b0);
      fetch(32'h4, 1'b0);
      fetch(32'h8, 1'b0);
      chk("t2_hold", resp_data, 32'h34011100);
      idle(1'b1);
      chk("t2_second", resp_data, 32'h34020020);
      chk("t2_ready_after_pop", {31'b0, req_ready}, 32'h1);
      idle(1'b1);

      // error flags
      fetch(32'h6, 1'b1);
      chk("t3_mis_err", 32'(resp_err), 32'h1);
      chk("t3_mis_data", resp_data, 32'h0);
      fetch(32'h1000, 1'b1);
      chk("t3_oor_err", 32'(resp_err), 32'h2);
      chk("t3_oor_addr", resp_addr, 32'h1000);
      idle(1'b1);

      // flush with two outstanding
      fetch(32'h0, 1'b0);
      fetch(32'h4, 1'b0);
      cycle(1'b1, 32'h8, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("t4_flush_valid", {31'b0, resp_valid}, 32'h0);
      fetch(32'h8, 1'b1);
      chk("t4_after_flush", resp_data, 32'h00220019);
      idle(1'b1);

      // read-first on same-cycle load, then new word, then dropped load
      cycle(1'b1, 32'h4, 1'b1, 1'b0, 1'b0, 1'b1, 32'h4, 32'hdeadbeef);
      chk("t5_old_word", resp_data, 32'h34020020);
      fetch(32'h4, 1'b1);
      chk("t5_new_word", resp_data, 32'hdeadbeef);
      cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h2000, 32'h12345678);
      fetch(32'h0, 1'b1);
      chk("t5_oor_load", resp_data, 32'h34011100);
      idle(1'b1);

      // reset mid-stream with two outstanding; memory retained
      fetch(32'h0, 1'b0);
      fetch(32'h8, 1'b0);
      cycle(1'b1, 32'hc, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h55555555);
      chk("t6_rst_valid", {31'b0, resp_valid}, 32'h0);
      chk("t6_rst_data", resp_data, 32'h0);
      chk("t6_rst_addr", resp_addr, 32'h0);
      cycle(1'b1, 32'hc, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
      fetch(32'h0, 1'b1);
      chk("t6_retained", resp_data, 32'h34011100);
      idle(1'b1);

      // random traffic against the model
      for (int n = 0; n < 400; n++) begin
         p  = int'($urandom_range(0, 99));
         a  = (p < 80) ? 32'($urandom_range(0, 1023) * 4) : 32'($urandom_range(0, 8191));
         la = (p < 50) ? 32'($urandom_range(0, 1023) * 4) : 32'($urandom_range(0, 8191));
         cycle($urandom_range(0, 3) != 0, a, $urandom_range(0, 2) != 0,
               $urandom_range(0, 29) == 0, $urandom_range(0, 49) == 0,
               $urandom_range(0, 4) == 0, la, $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
